top2_select: RTL and testbench

Streaming top-2 selector that sits directly upstream of the SFU check stage in the antenna-selection datapath. It accepts one antenna metric per valid cycle and labels each metric by its index within a frame of `NUM_ANT` antennas. At the end of each frame it emits the largest and second-largest metrics with their antenna labels, as a one-cycle-valid pair. The output pair feeds the SFU check stage's `x_0/x_1/x_label_0/x_label_1/x_valid` inputs directly.

---
 rtl/antsel_pkg.sv | 13 +
 rtl/top2_insert.sv | 48 ++++
 rtl/top2_select.sv | 102 ++++++++++
 tb/tb_top2_select.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/antsel_pkg.sv
// Shared antenna-selection types: default metric/label widths and the
// candidate record exchanged between the top-2 selector and the SFU check stage.
package antsel_pkg;

    localparam int DATA_WIDTH_DEF  = 8;
    localparam int LABEL_WIDTH_DEF = 3;

    typedef struct packed {
        logic [DATA_WIDTH_DEF-1:0]  data;
        logic [LABEL_WIDTH_DEF-1:0] label;
    } cand_t;

endpackage

// File: rtl/top2_insert.sv
// Combinational insertion of one candidate into a running best/second-best pair.
// Strict comparisons, so on equal metrics the earlier (lower) label keeps the higher slot.
module top2_insert
    import antsel_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int LABEL_WIDTH = LABEL_WIDTH_DEF
) (
    input  logic [DATA_WIDTH-1:0]  b0,
    input  logic [LABEL_WIDTH-1:0] l0,
    input  logic [DATA_WIDTH-1:0]  b1,
    input  logic [LABEL_WIDTH-1:0] l1,
    input  logic                   b1_ok,
    input  logic                   first,
    input  logic [DATA_WIDTH-1:0]  x_data,
    input  logic [LABEL_WIDTH-1:0] x_label,
    output logic [DATA_WIDTH-1:0]  b0_next,
    output logic [LABEL_WIDTH-1:0] l0_next,
    output logic [DATA_WIDTH-1:0]  b1_next,
    output logic [LABEL_WIDTH-1:0] l1_next,
    output logic                   b1_ok_next
);

    always_comb begin
        b0_next    = b0;
        l0_next    = l0;
        b1_next    = b1;
        l1_next    = l1;
        b1_ok_next = b1_ok;
        if (first) begin
            // Frame start: the second slot is stale until a later sample fills it.
            b0_next    = x_data;
            l0_next    = x_label;
            b1_ok_next = 1'b0;
        end else if (x_data > b0) begin
            b1_next    = b0;
            l1_next    = l0;
            b0_next    = x_data;
            l0_next    = x_label;
            b1_ok_next = 1'b1;
        end else if (!b1_ok || (x_data > b1)) begin
            b1_next    = x_data;
            l1_next    = x_label;
            b1_ok_next = 1'b1;
        end
    end

endmodule

// File: rtl/top2_select.sv
// Streaming top-2 selector: labels each accepted metric by its index in the frame
// and emits the best two with a one-cycle y_valid. Optional TOP2_FRAME_SYNC_EN adds x_first.
module top2_select
    import antsel_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int LABEL_WIDTH = LABEL_WIDTH_DEF,
    parameter int NUM_ANT     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   x_valid,
    input  logic [DATA_WIDTH-1:0]  x_data,
`ifdef TOP2_FRAME_SYNC_EN
    input  logic                   x_first,
`endif
    output logic [DATA_WIDTH-1:0]  y_0,
    output logic [DATA_WIDTH-1:0]  y_1,
    output logic [LABEL_WIDTH-1:0] y_label_0,
    output logic [LABEL_WIDTH-1:0] y_label_1,
    output logic                   y_valid
);

    if ((NUM_ANT < 2) || (NUM_ANT > (1 << LABEL_WIDTH))) begin : g_bad_num_ant
        $error("top2_select: NUM_ANT must be in 2..2**LABEL_WIDTH");
    end

    localparam logic [LABEL_WIDTH-1:0] LAST_IDX = LABEL_WIDTH'(NUM_ANT - 1);

    logic [LABEL_WIDTH-1:0] cnt_reg;
    logic [DATA_WIDTH-1:0]  b0_reg, b1_reg;
    logic [LABEL_WIDTH-1:0] l0_reg, l1_reg;
    logic                   b1_ok_reg;

    logic [LABEL_WIDTH-1:0] cnt_eff;
    logic                   is_first, is_last;
    logic [DATA_WIDTH-1:0]  b0_next, b1_next;
    logic [LABEL_WIDTH-1:0] l0_next, l1_next;
    logic                   b1_ok_next;

    // A frame-sync marker on a valid sample relabels it as index 0, dropping any partial frame.
`ifdef TOP2_FRAME_SYNC_EN
    assign cnt_eff = x_first ? '0 : cnt_reg;
`else
    assign cnt_eff = cnt_reg;
`endif
    assign is_first = (cnt_eff == '0);
    assign is_last  = (cnt_eff == LAST_IDX);

    top2_insert #(
        .DATA_WIDTH (DATA_WIDTH),
        .LABEL_WIDTH(LABEL_WIDTH)
    ) u_insert (
        .b0        (b0_reg),
        .l0        (l0_reg),
        .b1        (b1_reg),
        .l1        (l1_reg),
        .b1_ok     (b1_ok_reg),
        .first     (is_first),
        .x_data    (x_data),
        .x_label   (cnt_eff),
        .b0_next   (b0_next),
        .l0_next   (l0_next),
        .b1_next   (b1_next),
        .l1_next   (l1_next),
        .b1_ok_next(b1_ok_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg   <= '0;
            b0_reg    <= '0;
            l0_reg    <= '0;
            b1_reg    <= '0;
            l1_reg    <= '0;
            b1_ok_reg <= 1'b0;
            y_0       <= '0;
            y_1       <= '0;
            y_label_0 <= '0;
            y_label_1 <= '0;
            y_valid   <= 1'b0;
        end else begin
            y_valid <= 1'b0;
            if (x_valid) begin
                cnt_reg   <= is_last ? '0 : cnt_eff + LABEL_WIDTH'(1);
                b0_reg    <= b0_next;
                l0_reg    <= l0_next;
                b1_reg    <= b1_next;
                l1_reg    <= l1_next;
                b1_ok_reg <= b1_ok_next;
                if (is_last) begin
                    y_0       <= b0_next;
                    y_label_0 <= l0_next;
                    y_1       <= b1_next;
                    y_label_1 <= l1_next;
                    y_valid   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_top2_select.sv
// Directed bench for top2_select: a frame-level model (sort of the collected frame)
// checked against the DUT every cycle, plus literal expectations per test frame.
module tb_top2_select;

    localparam int DW = 8;
    localparam int LW = 3;
    localparam int NA = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          x_valid = 1'b0;
    logic [DW-1:0] x_data = '0;
    logic          x_first = 1'b0;
    logic [DW-1:0] y_0, y_1;
    logic [LW-1:0] y_label_0, y_label_1;
    logic          y_valid;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Model state: samples of the current frame and the expected registered outputs.
    int fr[$];
    int exp_y0 = 0, exp_y1 = 0, exp_l0 = 0, exp_l1 = 0, exp_v = 0;
    int pulses = 0;

    always #5 clk = ~clk;

    top2_select #(.DATA_WIDTH(DW), .LABEL_WIDTH(LW), .NUM_ANT(NA)) dut (
        .clk      (clk),
        .rst      (rst),
        .x_valid  (x_valid),
        .x_data   (x_data),
`ifdef TOP2_FRAME_SYNC_EN
        .x_first  (x_first),
`endif
        .y_0      (y_0),
        .y_1      (y_1),
        .y_label_0(y_label_0),
        .y_label_1(y_label_1),
        .y_valid  (y_valid)
    );

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
        end
    endtask

    // Top-2 by rank: highest value wins, ties go to the earliest index.
    task automatic model_result();
        int i0, i1;
        i0 = 0;
        for (int i = 1; i < fr.size(); i++) if (fr[i] > fr[i0]) i0 = i;
        i1 = -1;
        for (int i = 0; i < fr.size(); i++)
            if (i != i0 && (i1 < 0 || fr[i] > fr[i1])) i1 = i;
        exp_y0 = fr[i0]; exp_l0 = i0;
        exp_y1 = fr[i1]; exp_l1 = i1;
        exp_v  = 1;
    endtask

    task automatic model_update(input bit r, input bit v, input int d, input bit f);
        exp_v = 0;
        if (r) begin
            fr.delete();
            exp_y0 = 0; exp_y1 = 0; exp_l0 = 0; exp_l1 = 0;
        end else if (v) begin
`ifdef TOP2_FRAME_SYNC_EN
            if (f) fr.delete();
`else
            if (f) begin end
`endif
            fr.push_back(d);
            if (fr.size() == NA) begin
                model_result();
                fr.delete();
            end
        end
    endtask

    task automatic step(input bit r, input bit v, input int d, input bit f);
        rst = r; x_valid = v; x_data = DW'(d); x_first = f;
        @(posedge clk);
        model_update(r, v, d, f);
        #1;
        rst = 1'b0; x_valid = 1'b0; x_first = 1'b0;
    endtask

    task automatic send(input int d);
        step(1'b0, 1'b1, d, 1'b0);
    endtask

    task automatic lit(input string name, input int a0, input int b0, input int a1, input int b1);
        chk({name, ".y_valid"}, int'(y_valid), 1);
        chk({name, ".y_0"}, int'(y_0), a0);
        chk({name, ".y_label_0"}, int'(y_label_0), b0);
        chk({name, ".y_1"}, int'(y_1), a1);
        chk({name, ".y_label_1"}, int'(y_label_1), b1);
    endtask

    // Every-cycle comparison against the model, plus result invariants.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("y_valid", int'(y_valid), exp_v);
            chk("y_0", int'(y_0), exp_y0);
            chk("y_1", int'(y_1), exp_y1);
            chk("y_label_0", int'(y_label_0), exp_l0);
            chk("y_label_1", int'(y_label_1), exp_l1);
            if (y_valid) begin
                pulses++;
                chk("inv_labels_differ", int'(y_label_0 != y_label_1), 1);
                chk("inv_order", int'(y_0 >= y_1), 1);
                chk("inv_label_range", int'(y_label_0 < NA && y_label_1 < NA), 1);
            end
        end
    end

    int basic_v[8] = '{10, 50, 30, 70, 20, 60, 40, 0};
    int bb_a[8]    = '{1, 2, 3, 4, 5, 6, 7, 200};
    int bb_b[8]    = '{150, 9, 8, 7, 6, 5, 4, 3};
    int sync_v[8]  = '{5, 60, 7, 80, 9, 10, 11, 12};

    initial begin
        step(1'b1, 1'b0, 0, 1'b0);
        step(1'b1, 1'b0, 0, 1'b0);
        cmp_en = 1'b1;
        @(negedge clk);
        chk("reset.y_valid", int'(y_valid), 0);
        chk("reset.y_0", int'(y_0), 0);
        @(posedge clk); #1;

        // Basic frame
        foreach (basic_v[i]) send(basic_v[i]);
        lit("basic", 70, 3, 60, 5);
        step(1'b0, 1'b0, 0, 1'b0);

        // Ties
        for (int i = 0; i < NA; i++) send(25);
        lit("ties", 25, 0, 25, 1);
        step(1'b0, 1'b0, 0, 1'b0);

        // Descending with bubbles on alternate cycles
        for (int i = 0; i < NA; i++) begin
            send(90 - 10 * i);
            if (i != NA - 1) begin
                chk("bubble.no_early_pulse", int'(y_valid), 0);
                step(1'b0, 1'b0, 0, 1'b0);
            end
        end
        lit("desc", 90, 0, 80, 1);
        step(1'b0, 1'b0, 0, 1'b0);

        // Back-to-back frames
        foreach (bb_a[i]) send(bb_a[i]);
        lit("b2b_a", 200, 7, 7, 6);
        foreach (bb_b[i]) send(bb_b[i]);
        lit("b2b_b", 150, 0, 9, 1);
        step(1'b0, 1'b0, 0, 1'b0);

        // Mid-frame reset, then a fresh frame
        for (int i = 0; i < 5; i++) send(250);
        step(1'b1, 1'b0, 0, 1'b0);
        chk("midreset.y_0", int'(y_0), 0);
        foreach (basic_v[i]) send(basic_v[i]);
        lit("after_reset", 70, 3, 60, 5);

        // Reset coinciding with the last sample suppresses the pulse
        for (int i = 0; i < NA - 1; i++) send(i + 1);
        step(1'b1, 1'b1, 99, 1'b0);
        chk("reset_on_last.y_valid", int'(y_valid), 0);
        foreach (basic_v[i]) send(basic_v[i]);
        lit("post_reset_on_last", 70, 3, 60, 5);

`ifdef TOP2_FRAME_SYNC_EN
        for (int i = 0; i < 3; i++) send(100);
        step(1'b0, 1'b1, sync_v[0], 1'b1);
        for (int i = 1; i < NA; i++) begin
            chk("sync.no_early_pulse", int'(y_valid), 0);
            send(sync_v[i]);
        end
        lit("sync", 80, 3, 60, 1);
`else
        // Free-running count: an extra frame right after relies only on reset alignment.
        foreach (sync_v[i]) send(sync_v[i]);
        lit("freerun", 80, 3, 60, 1);
`endif
        step(1'b0, 1'b0, 0, 1'b0);
        step(1'b0, 1'b0, 0, 1'b0);
        @(negedge clk);
        cmp_en = 1'b0;
        chk("pulse_count", pulses, 8);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
